// File: rtl/mem_bus_stage_pkg.sv
// Shared widths, opcodes and types for the MEM stage bus interface.
// The constants mirror the pipeline-wide defines so this slice stands alone.
package mem_bus_stage_pkg;

  localparam int unsigned INST_ADDR_W = 32;
  localparam int unsigned REG_ADDR_W  = 5;
  localparam int unsigned REG_W       = 32;
  localparam int unsigned ALUOP_W     = 8;
  localparam int unsigned SEL_W       = 4;

  localparam logic [REG_ADDR_W-1:0] NOP_REG_ADDR = 5'b00000;

  localparam logic [ALUOP_W-1:0] EXE_LB_OP  = 8'b1110_0000;
  localparam logic [ALUOP_W-1:0] EXE_LBU_OP = 8'b1110_0100;
  localparam logic [ALUOP_W-1:0] EXE_LH_OP  = 8'b1110_0001;
  localparam logic [ALUOP_W-1:0] EXE_LHU_OP = 8'b1110_0101;
  localparam logic [ALUOP_W-1:0] EXE_LW_OP  = 8'b1110_0011;
  localparam logic [ALUOP_W-1:0] EXE_SB_OP  = 8'b1110_1000;
  localparam logic [ALUOP_W-1:0] EXE_SH_OP  = 8'b1110_1001;
  localparam logic [ALUOP_W-1:0] EXE_SW_OP  = 8'b1110_1011;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_DONE = 2'd2,
    ST_ERR  = 2'd3
  } state_e;

  typedef enum logic [1:0] {
    SZ_NONE = 2'd0,
    SZ_BYTE = 2'd1,
    SZ_HALF = 2'd2,
    SZ_WORD = 2'd3
  } acc_size_e;

  // Registered data-bus request payload
  typedef struct packed {
    logic               we;
    logic [SEL_W-1:0]   sel;
    logic [REG_W-1:0]   addr;
    logic [REG_W-1:0]   data;
  } mem_req_t;

  function automatic acc_size_e op_size(input logic [ALUOP_W-1:0] aluop);
    acc_size_e sz;
    case (aluop)
      EXE_LB_OP, EXE_LBU_OP, EXE_SB_OP: sz = SZ_BYTE;
      EXE_LH_OP, EXE_LHU_OP, EXE_SH_OP: sz = SZ_HALF;
      EXE_LW_OP, EXE_SW_OP:             sz = SZ_WORD;
      default:                          sz = SZ_NONE;
    endcase
    return sz;
  endfunction

  function automatic logic op_is_store(input logic [ALUOP_W-1:0] aluop);
    return (aluop == EXE_SB_OP) || (aluop == EXE_SH_OP) || (aluop == EXE_SW_OP);
  endfunction

  function automatic logic op_is_signed(input logic [ALUOP_W-1:0] aluop);
    return (aluop == EXE_LB_OP) || (aluop == EXE_LH_OP);
  endfunction

endpackage

// File: rtl/mem_lane_align.sv
// Big-endian byte-lane steering for the MEM stage: byte enables, store
// replication, load extraction/extension and alignment check.
module mem_lane_align
  import mem_bus_stage_pkg::*;
(
  input  logic [ALUOP_W-1:0] i_aluop,
  input  logic [1:0]         i_addr_lo,
  input  logic [REG_W-1:0]   i_reg2,
  input  logic [REG_W-1:0]   i_rdata,
  output logic [SEL_W-1:0]   o_sel,
  output logic [REG_W-1:0]   o_wdata_bus,
  output logic [REG_W-1:0]   o_load_ext,
  output logic               o_misaligned
);

  acc_size_e   w_size;
  logic        w_signed;
  logic [7:0]  w_byte;
  logic [15:0] w_half;

  assign w_size   = op_size(i_aluop);
  assign w_signed = op_is_signed(i_aluop);

  // Lane 0 is the most significant byte of the bus word
  always_comb begin : lane_pick
    w_byte = i_rdata[31:24];
    w_half = i_rdata[31:16];
    case (i_addr_lo)
      2'b01:   w_byte = i_rdata[23:16];
      2'b10:   w_byte = i_rdata[15:8];
      2'b11:   w_byte = i_rdata[7:0];
      default: w_byte = i_rdata[31:24];
    endcase
    if (i_addr_lo[1]) begin
      w_half = i_rdata[15:0];
    end
  end

  always_comb begin : lane_map
    o_sel        = '0;
    o_wdata_bus  = i_reg2;
    o_load_ext   = i_rdata;
    o_misaligned = 1'b0;
    case (w_size)
      SZ_BYTE: begin
        o_sel       = SEL_W'(4'b1000 >> i_addr_lo);
        o_wdata_bus = {4{i_reg2[7:0]}};
        o_load_ext  = w_signed ? {{24{w_byte[7]}}, w_byte} : {24'd0, w_byte};
      end
      SZ_HALF: begin
        o_sel        = i_addr_lo[1] ? 4'b0011 : 4'b1100;
        o_wdata_bus  = {2{i_reg2[15:0]}};
        o_load_ext   = w_signed ? {{16{w_half[15]}}, w_half} : {16'd0, w_half};
        o_misaligned = i_addr_lo[0];
      end
      SZ_WORD: begin
        o_sel        = 4'b1111;
        o_misaligned = (i_addr_lo != 2'b00);
      end
      default: begin
        o_sel = '0;
      end
    endcase
  end

endmodule

// File: rtl/mem_bus_stage.sv
// MEM stage of the 5-stage MIPS pipeline: pass-through for ALU ops, a
// registered req/ack data-bus transaction with timeout for loads and stores.
module mem_bus_stage
  import mem_bus_stage_pkg::*;
#(
  parameter int unsigned ACK_TIMEOUT = 255
)
(
  input  logic                   clk,
  input  logic                   rst,
  input  logic [INST_ADDR_W-1:0] pc_i,
  input  logic [REG_ADDR_W-1:0]  rw_i,
  input  logic                   wreg_i,
  input  logic [REG_W-1:0]       wdata_i,
  input  logic [ALUOP_W-1:0]     aluop_i,
  input  logic [REG_W-1:0]       mem_addr_i,
  input  logic [REG_W-1:0]       reg2_i,
  output logic [INST_ADDR_W-1:0] pc_o,
  output logic [REG_ADDR_W-1:0]  rw_o,
  output logic                   wreg_o,
  output logic [REG_W-1:0]       wdata_o,
  output logic                   stallreq_o,
  output logic                   misalign_o,
  output logic                   bus_err_o,
  output logic                   mem_ce_o,
  output logic                   mem_we_o,
  output logic [REG_W-1:0]       mem_addr_o,
  output logic [SEL_W-1:0]       mem_sel_o,
  output logic [REG_W-1:0]       mem_data_o,
  input  logic [REG_W-1:0]       mem_data_i,
  input  logic                   mem_ack_i
);

  localparam int unsigned       CNT_W    = $clog2(ACK_TIMEOUT);
  localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(ACK_TIMEOUT - 1);

  state_e             r_state;
  state_e             w_state_nxt;
  logic [CNT_W-1:0]   r_cnt;
  logic               r_mem_ce;
  mem_req_t           r_req;
  logic [REG_W-1:0]   r_load_data;
  logic               r_is_store;

  logic               w_is_mem;
  logic               w_is_store;
  logic               w_launch;
  logic               w_capture;
  logic               w_abort;
  logic [SEL_W-1:0]   w_sel;
  logic [REG_W-1:0]   w_wdata_bus;
  logic [REG_W-1:0]   w_load_ext;
  logic               w_misaligned;

  assign w_is_mem   = (op_size(aluop_i) != SZ_NONE);
  assign w_is_store = op_is_store(aluop_i);

  mem_lane_align u_lane (
    .i_aluop      (aluop_i),
    .i_addr_lo    (mem_addr_i[1:0]),
    .i_reg2       (reg2_i),
    .i_rdata      (mem_data_i),
    .o_sel        (w_sel),
    .o_wdata_bus  (w_wdata_bus),
    .o_load_ext   (w_load_ext),
    .o_misaligned (w_misaligned)
  );

  always_ff @(posedge clk) begin : state_reg
    if (rst) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next state and the combinational pipeline outputs
  always_comb begin : fsm_comb
    w_state_nxt = r_state;
    w_launch    = 1'b0;
    w_capture   = 1'b0;
    w_abort     = 1'b0;
    pc_o        = pc_i;
    rw_o        = rw_i;
    wreg_o      = wreg_i;
    wdata_o     = wdata_i;
    stallreq_o  = 1'b0;
    misalign_o  = 1'b0;
    bus_err_o   = 1'b0;

    case (r_state)
      ST_IDLE: begin
        if (w_is_mem) begin
          wreg_o = 1'b0;
          if (w_misaligned) begin
            misalign_o = 1'b1;
          end else begin
            stallreq_o  = 1'b1;
            w_launch    = 1'b1;
            w_state_nxt = ST_WAIT;
          end
        end
      end
      ST_WAIT: begin
        stallreq_o = 1'b1;
        wreg_o     = 1'b0;
        // An ack arriving on the last allowed cycle still completes the access
        if (mem_ack_i) begin
          w_capture   = 1'b1;
          w_state_nxt = ST_DONE;
        end else if (r_cnt == CNT_LAST) begin
          w_abort     = 1'b1;
          w_state_nxt = ST_ERR;
        end
      end
      ST_DONE: begin
        w_state_nxt = ST_IDLE;
        if (r_is_store) begin
          wreg_o = 1'b0;
        end else begin
          wdata_o = r_load_data;
        end
      end
      ST_ERR: begin
        w_state_nxt = ST_IDLE;
        wreg_o      = 1'b0;
        bus_err_o   = 1'b1;
      end
      default: begin
        w_state_nxt = ST_IDLE;
      end
    endcase

    if (rst) begin
      w_launch   = 1'b0;
      w_capture  = 1'b0;
      w_abort    = 1'b0;
      pc_o       = '0;
      rw_o       = NOP_REG_ADDR;
      wreg_o     = 1'b0;
      wdata_o    = '0;
      stallreq_o = 1'b0;
      misalign_o = 1'b0;
      bus_err_o  = 1'b0;
    end
  end

  // Bus request registers, wait counter and captured load data
  always_ff @(posedge clk) begin : bus_regs
    if (rst) begin
      r_mem_ce    <= 1'b0;
      r_req       <= '0;
      r_cnt       <= '0;
      r_load_data <= '0;
      r_is_store  <= 1'b0;
    end else begin
      if (w_launch) begin
        r_mem_ce   <= 1'b1;
        r_req.we   <= w_is_store;
        r_req.sel  <= w_sel;
        r_req.addr <= {mem_addr_i[REG_W-1:2], 2'b00};
        r_req.data <= w_wdata_bus;
        r_cnt      <= '0;
        r_is_store <= w_is_store;
      end else if (r_state == ST_WAIT) begin
        r_cnt <= r_cnt + CNT_W'(1);
      end
      if (w_capture) begin
        r_mem_ce    <= 1'b0;
        r_req.we    <= 1'b0;
        r_req.sel   <= '0;
        r_load_data <= w_load_ext;
      end
      if (w_abort) begin
        r_mem_ce  <= 1'b0;
        r_req.we  <= 1'b0;
        r_req.sel <= '0;
      end
    end
  end

  assign mem_ce_o   = r_mem_ce;
  assign mem_we_o   = r_req.we;
  assign mem_sel_o  = r_req.sel;
  assign mem_addr_o = r_req.addr;
  assign mem_data_o = r_req.data;

endmodule
